// File: rtl/bitvault_arbiter_if.sv
// Bus bundle between the two BitVault requesters / register file and the
// arbiter. The slave modport is the arbiter's view; master is the
// environment (requesters plus register-file read data).
interface bitvault_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          req0;
  logic          req1;
  logic          wr0;
  logic          wr1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, rf_rdata,
    output ack0, ack1, rdata0, rdata1, rf_we, rf_waddr, rf_wdata, rf_raddr, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, rf_rdata,
    input  ack0, ack1, rdata0, rdata1, rf_we, rf_waddr, rf_wdata, rf_raddr, busy
  );
endinterface

// File: rtl/bitvault_arbiter.sv
// Two-requester arbiter in front of the BitVault register file.
// A grant in IDLE latches the winner's op, SERVE drives the register file
// for one cycle, and the winner's ack pulses in the cycle after SERVE.
// Build option: define BITVAULT_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 wins every tie); otherwise ties are broken round-robin.
module bitvault_arbiter #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  bitvault_arbiter_if.slave bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  logic [0:0]    r_state;
  logic          r_op_wr;
  logic          r_op_id;
  logic [AW-1:0] r_op_addr;
  logic [DW-1:0] r_op_wdata;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic w_req0;
  logic w_req1;
  logic w_grant;
  logic w_winner;
  logic w_serve;

  // A requester being acked this cycle is still holding req for the op that
  // just finished, so it must not be granted again.
  assign w_req0  = bus.req0 & ~r_ack0;
  assign w_req1  = bus.req1 & ~r_ack1;
  assign w_grant = (r_state == ST_IDLE) & (w_req0 | w_req1);
  assign w_serve = (r_state == ST_SERVE);

`ifdef BITVAULT_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is requesting; no grant history is kept.
  assign w_winner = ~w_req0;
`else
  logic r_last_grant;

  // On a tie the requester that was not granted last time wins.
  assign w_winner = (w_req0 & w_req1) ? ~r_last_grant : w_req1;

  // Track the most recent winner; reset value lets requester 0 win first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_last_grant <= w_winner;
    end
  end
`endif

  // FSM plus op latch: inputs are sampled only in the grant cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op_wr    <= 1'b0;
      r_op_id    <= 1'b0;
      r_op_addr  <= '0;
      r_op_wdata <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_grant) begin
        r_state    <= ST_SERVE;
        r_op_id    <= w_winner;
        r_op_wr    <= w_winner ? bus.wr1    : bus.wr0;
        r_op_addr  <= w_winner ? bus.addr1  : bus.addr0;
        r_op_wdata <= w_winner ? bus.wdata1 : bus.wdata0;
      end
    end else begin
      r_state <= ST_IDLE;
    end
  end

  // Completion: ack pulse and read capture for the winner at the end of SERVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_ack0 <= w_serve & ~r_op_id;
      r_ack1 <= w_serve & r_op_id;
      if (w_serve && !r_op_wr) begin
        if (r_op_id) begin
          r_rdata1 <= bus.rf_rdata;
        end else begin
          r_rdata0 <= bus.rf_rdata;
        end
      end
    end
  end

  // Gating rf_we with rst_n aborts a write caught by reset in SERVE.
  assign bus.rf_we    = w_serve & r_op_wr & rst_n;
  assign bus.rf_waddr = r_op_addr;
  assign bus.rf_raddr = r_op_addr;
  assign bus.rf_wdata = r_op_wdata;
  assign bus.busy     = w_serve;
  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
endmodule

// File: tb/tb_bitvault_arbiter.sv
// Bench for bitvault_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_bitvault_arbiter;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NR = 1 << AW;
`ifdef BITVAULT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   both_cnt = 0;

  always #5 clk = ~clk;

  bitvault_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  bitvault_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Register file with combinational read, cleared by reset.
  logic [DW-1:0] tb_rf [0:NR-1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) tb_rf[i] <= '0;
    end else if (bus.rf_we) begin
      tb_rf[bus.rf_waddr] <= bus.rf_wdata;
    end
  end
  assign bus.rf_rdata = tb_rf[bus.rf_raddr];

  // Count every cycle in which both acks are high.
  always @(negedge clk) begin
    if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both_cnt = both_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int id, input logic rq, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin
      bus.req0 = rq; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = rq; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one op and wait (bounded) for its ack; returns with req dropped.
  task automatic do_op(input int id, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic ok);
    ok = 1'b0;
    drive(id, 1'b1, wr, a, d);
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if ((id == 0 && bus.ack0 === 1'b1) || (id == 1 && bus.ack1 === 1'b1)) ok = 1'b1;
    end
    drive(id, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.rf_we, bus.ack0, bus.ack1} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy,rf_we,ack0,ack1=%b expected 0000",
               {bus.busy, bus.rf_we, bus.ack0, bus.ack1});
    end
    vectors++;
    if ({bus.rf_waddr, bus.rf_raddr, bus.rf_wdata} !== {AW'(0), AW'(0), DW'(0)}) begin
      miscompares++;
      $display("FAIL reset_rf: waddr=%h raddr=%h wdata=%h expected 0",
               bus.rf_waddr, bus.rf_raddr, bus.rf_wdata);
    end
    vectors++;
    if ({bus.rdata0, bus.rdata1} !== {DW'(0), DW'(0)}) begin
      miscompares++;
      $display("FAIL reset_rdata: rdata0=%h rdata1=%h expected 0", bus.rdata0, bus.rdata1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    apply_reset();
    drive(0, 1'b1, 1'b1, 2'd2, 8'hA5);
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.rf_we} !== 2'b11 || bus.rf_waddr !== 2'd2 || bus.rf_wdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL wr_serve: busy=%b rf_we=%b waddr=%0d wdata=%h expected 1 1 2 a5",
               bus.busy, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.rf_we} !== 4'b1000) begin
      miscompares++;
      $display("FAIL wr_ack: ack0,ack1,busy,rf_we=%b expected 1000",
               {bus.ack0, bus.ack1, bus.busy, bus.rf_we});
    end
    // New read request while ack0 is high: masked this cycle.
    drive(0, 1'b1, 1'b0, 2'd2, 8'h00);
    @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL rd_grant_cycle: ack0,busy=%b expected 00", {bus.ack0, bus.busy});
    end
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.rf_we} !== 2'b10 || bus.rf_raddr !== 2'd2) begin
      miscompares++;
      $display("FAIL rd_serve: busy,rf_we=%b raddr=%0d expected 10 2",
               {bus.busy, bus.rf_we}, bus.rf_raddr);
    end
    @(negedge clk);
    vectors++;
    if (bus.ack0 !== 1'b1 || bus.rdata0 !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_ack: ack0=%b rdata0=%h expected 1 a5", bus.ack0, bus.rdata0);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_tie();
    logic [1:0] exp_a;
    logic [1:0] first;
    apply_reset();
    // First tie after reset: requester 0, then requester 1 two cycles later.
    drive(0, 1'b1, 1'b0, 2'd2, '0);
    drive(1, 1'b1, 1'b0, 2'd1, '0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_a = (k == 2) ? 2'b10 : (k == 4) ? 2'b01 : 2'b00;
      vectors++;
      if ({bus.ack0, bus.ack1} !== exp_a) begin
        miscompares++;
        $display("FAIL tie_reset k=%0d: ack0,ack1=%b expected %b", k, {bus.ack0, bus.ack1}, exp_a);
      end
      if (bus.ack0 === 1'b1) drive(0, 1'b0, 1'b0, '0, '0);
      if (bus.ack1 === 1'b1) drive(1, 1'b0, 1'b0, '0, '0);
    end
    // Serve requester 0 alone so it becomes last served.
    drive(0, 1'b1, 1'b1, 2'd0, 8'h5A);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      exp_a = (k == 2) ? 2'b10 : 2'b00;
      vectors++;
      if ({bus.ack0, bus.ack1} !== exp_a) begin
        miscompares++;
        $display("FAIL tie_solo k=%0d: ack0,ack1=%b expected %b", k, {bus.ack0, bus.ack1}, exp_a);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    // Tie with requester 0 last served: round-robin picks 1, fixed picks 0.
    first = FIXED ? 2'b10 : 2'b01;
    drive(0, 1'b1, 1'b0, 2'd0, '0);
    drive(1, 1'b1, 1'b0, 2'd3, '0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_a = (k == 2) ? first : (k == 4) ? ~first : 2'b00;
      vectors++;
      if ({bus.ack0, bus.ack1} !== exp_a) begin
        miscompares++;
        $display("FAIL tie_second k=%0d: ack0,ack1=%b expected %b", k, {bus.ack0, bus.ack1}, exp_a);
      end
      if (bus.ack0 === 1'b1) drive(0, 1'b0, 1'b0, '0, '0);
      if (bus.ack1 === 1'b1) drive(1, 1'b0, 1'b0, '0, '0);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_contention();
    int seq[$];
    int tim[$];
    apply_reset();
    drive(0, 1'b1, 1'b0, AW'($urandom_range(0, NR - 1)), '0);
    drive(1, 1'b1, 1'b0, AW'($urandom_range(0, NR - 1)), '0);
    for (int k = 1; k <= 60 && seq.size() < 8; k++) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1) begin
        seq.push_back(0); tim.push_back(k);
        drive(0, 1'b1, 1'b0, AW'($urandom_range(0, NR - 1)), '0);
      end
      if (bus.ack1 === 1'b1) begin
        seq.push_back(1); tim.push_back(k);
        drive(1, 1'b1, 1'b0, AW'($urandom_range(0, NR - 1)), '0);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (seq.size() < 8) begin
      miscompares++;
      $display("FAIL contention_count: %0d acks seen, required 8", seq.size());
    end
    for (int i = 0; i < seq.size() && i < 8; i++) begin
      vectors++;
      if (seq[i] !== (i % 2) || tim[i] !== 2 * (i + 1)) begin
        miscompares++;
        $display("FAIL contention_ack%0d: requester %0d at cycle %0d, expected requester %0d at cycle %0d",
                 i, seq[i], tim[i], i % 2, 2 * (i + 1));
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    drive(0, 1'b1, 1'b1, 2'd1, 8'h3C);
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_serve: busy=%b expected 1", bus.busy);
    end
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    vectors++;
    if (bus.rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_we: rf_we=%b expected 0", bus.rf_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL midrst_after%0d: ack0,ack1,busy=%b expected 000", k, {bus.ack0, bus.ack1, bus.busy});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_isolation();
    logic ok;
    int   both_start;
    apply_reset();
    both_start = both_cnt;
    do_op(0, 1'b1, 2'd0, 8'h11, ok);
    do_op(1, 1'b1, 2'd3, 8'h77, ok);
    do_op(0, 1'b0, 2'd0, 8'h00, ok);
    vectors++;
    if (!ok || bus.rdata0 !== 8'h11) begin
      miscompares++;
      $display("FAIL iso_rd0: acked=%b rdata0=%h expected 1 11", ok, bus.rdata0);
    end
    do_op(1, 1'b0, 2'd3, 8'h00, ok);
    vectors++;
    if (!ok || bus.rdata1 !== 8'h77 || bus.rdata0 !== 8'h11) begin
      miscompares++;
      $display("FAIL iso_rd1: acked=%b rdata1=%h rdata0=%h expected 1 77 11", ok, bus.rdata1, bus.rdata0);
    end
    @(negedge clk);
    vectors++;
    if (both_cnt !== both_start) begin
      miscompares++;
      $display("FAIL iso_exclusive: %0d cycles with both acks, expected 0", both_cnt - both_start);
    end
  endtask

  // Randomized traffic against a transaction-level model: a grant may happen
  // once the previous one is 2 cycles old, acked requesters are excluded in
  // their ack cycle, and the register contents are tracked per grant.
  task automatic test_random(input int ncyc);
    int            exp_ack [2];
    int            exp_busy, next_free, last, w, txns, both_start;
    logic          hold [2];
    logic          op_wr [2];
    logic [AW-1:0] op_a [2];
    logic [DW-1:0] op_d [2];
    logic [DW-1:0] cur_rd [2];
    logic [DW-1:0] pend_rd [2];
    logic          pend_v [2];
    logic          s_wr, p0, p1;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_d;
    logic [DW-1:0] mm [0:NR-1];
    apply_reset();
    both_start = both_cnt;
    for (int i = 0; i < NR; i++) mm[i] = '0;
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = -10; hold[i] = 1'b0; cur_rd[i] = '0; pend_rd[i] = '0; pend_v[i] = 1'b0;
      op_wr[i] = 1'b0; op_a[i] = '0; op_d[i] = '0;
    end
    exp_busy = -10; next_free = 0; last = 1; txns = 0;
    s_wr = 1'b0; s_a = '0; s_d = '0;
    for (int c = 0; c < ncyc; c++) begin
      vectors++;
      if ({bus.ack0, bus.ack1, bus.busy, bus.rf_we} !==
          {exp_ack[0] == c, exp_ack[1] == c, exp_busy == c, (exp_busy == c) && s_wr}) begin
        miscompares++;
        $display("FAIL rnd_ctrl c=%0d: ack0,ack1,busy,rf_we=%b expected %b", c,
                 {bus.ack0, bus.ack1, bus.busy, bus.rf_we},
                 {exp_ack[0] == c, exp_ack[1] == c, exp_busy == c, (exp_busy == c) && s_wr});
      end
      vectors++;
      if ({bus.rf_waddr, bus.rf_raddr, bus.rf_wdata} !== {s_a, s_a, s_d}) begin
        miscompares++;
        $display("FAIL rnd_rf c=%0d: waddr=%0d raddr=%0d wdata=%h expected %0d %0d %h", c,
                 bus.rf_waddr, bus.rf_raddr, bus.rf_wdata, s_a, s_a, s_d);
      end
      for (int i = 0; i < 2; i++) begin
        if (exp_ack[i] == c) begin
          if (pend_v[i]) cur_rd[i] = pend_rd[i];
          hold[i] = 1'b0;
          txns++;
          $display("txn %0d: req%0d %s addr=%0d data=%02h acked at cycle %0d", txns, i,
                   op_wr[i] ? "write" : "read ", op_a[i], op_wr[i] ? op_d[i] : pend_rd[i], c);
        end
      end
      vectors++;
      if ({bus.rdata0, bus.rdata1} !== {cur_rd[0], cur_rd[1]}) begin
        miscompares++;
        $display("FAIL rnd_rdata c=%0d: rdata0=%h rdata1=%h expected %h %h", c,
                 bus.rdata0, bus.rdata1, cur_rd[0], cur_rd[1]);
      end
      for (int i = 0; i < 2; i++) begin
        if (!hold[i] && $urandom_range(0, 3) != 0) begin
          hold[i]  = 1'b1;
          op_wr[i] = 1'($urandom_range(0, 1));
          op_a[i]  = AW'($urandom_range(0, NR - 1));
          op_d[i]  = DW'($urandom);
        end
        drive(i, hold[i], op_wr[i], op_a[i], op_d[i]);
      end
      p0 = hold[0] && (exp_ack[0] != c);
      p1 = hold[1] && (exp_ack[1] != c);
      if (c >= next_free && (p0 || p1)) begin
        if (p0 && p1) w = FIXED ? 0 : 1 - last;
        else          w = p0 ? 0 : 1;
        last = w;
        exp_busy = c + 1; exp_ack[w] = c + 2; next_free = c + 2;
        s_wr = op_wr[w]; s_a = op_a[w]; s_d = op_d[w];
        if (s_wr) begin
          mm[s_a] = s_d; pend_v[w] = 1'b0;
        end else begin
          pend_rd[w] = mm[s_a]; pend_v[w] = 1'b1;
        end
      end
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (both_cnt !== both_start) begin
      miscompares++;
      $display("FAIL rnd_exclusive: %0d cycles with both acks, expected 0", both_cnt - both_start);
    end
    vectors++;
    if (txns < 50) begin
      miscompares++;
      $display("FAIL rnd_progress: %0d transactions completed, expected at least 50", txns);
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_write_read();
    test_tie();
    test_contention();
    test_reset_mid_op();
    test_isolation();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
